qmem_ram: RTL and testbench

//  Single-port 64-bit local memory serving the unified qmem bus produced by the I/D qmem

---
 rtl/qmem_ram.sv | 110 +++++++++++
 tb/tb_qmem_ram.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/qmem_ram.sv
// qmem_ram: single-port 64-bit local memory behind the unified I/D qmem bus.
// It has programmable wait states, byte-lane writes, and read data that is registered one cycle after the ack.
module qmem_ram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_stb,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_byte_en,
  input  logic [63:0] mem_wdata,
  output logic        mem_ack,
  output logic [63:0] mem_rdata,
  output logic        mem_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH need not be a power of two, so check the range on the full word index
  function automatic logic in_range_f(input logic [28:0] widx);
    in_range_f = ({3'b000, widx} < 32'(DEPTH));
  endfunction

  function automatic logic [63:0] byte_merge_f(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  lane_en);
    logic [63:0] merged;
    merged = old_word;
    for (int k = 0; k < 8; k++) begin
      if (lane_en[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    byte_merge_f = merged;
  endfunction

  logic [63:0]      mem_q [DEPTH];
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             ack_s;
  logic             in_range_s;
  logic             is_write_s;
  logic [28:0]      widx_s;
  logic [IDX_W-1:0] idx_s;
  logic             unused_s;

  assign widx_s     = mem_addr[31:3];
  assign idx_s      = widx_s[IDX_W-1:0];
  assign in_range_s = in_range_f(widx_s);
  assign is_write_s = (mem_byte_en != 8'h00);
  assign unused_s   = &{1'b0, mem_addr[2:0]};

  // Ack is gated by rst_n so that nothing is accepted while reset is held.
  assign ack_s = rst_n & mem_stb & (cnt_q == 4'(WAIT_STATES));

  // Next-state logic for the wait counter, read-data register and error pulse
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (!mem_stb || ack_s) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    if (ack_s && !is_write_s) begin
      if (in_range_s) begin
        rdata_d = mem_q[idx_s];
      end else begin
        rdata_d = 64'd0;
      end
    end else begin
      rdata_d = rdata_q;
    end
    if (ack_s && !in_range_s) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is not reset. A write lands at the ack edge, so a read on the next ack sees it.
  always_ff @(posedge clk) begin
    if (ack_s && is_write_s && in_range_s) begin
      mem_q[idx_s] <= byte_merge_f(mem_q[idx_s], mem_wdata, mem_byte_en);
    end
  end

  assign mem_ack   = ack_s;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_qmem_ram.sv
// Directed bench for qmem_ram: three instances with wait states 0, 2 and 3.
// All expected values are hand-computed constants.
module tb_qmem_ram;

  logic        clk;
  logic        rst_n;
  logic        stb  [3];
  logic [31:0] addr [3];
  logic [7:0]  be   [3];
  logic [63:0] wd   [3];
  logic        ack  [3];
  logic [63:0] rd   [3];
  logic        err  [3];

  int n_chk;
  int n_bad;

  localparam logic [63:0] D3 = 64'h3333_4444_5555_6666;
  localparam logic [63:0] D4 = 64'h4444_0000_4444_0000;
  localparam logic [63:0] D5 = 64'h5555_1234_5678_9ABC;
  localparam logic [63:0] C0 = 64'hC0C0_C0C0_0102_0304;
  localparam logic [63:0] CT = 64'hDEAD_BEEF_0BAD_F00D;

  qmem_ram #(.DEPTH(1024), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .mem_stb(stb[0]), .mem_addr(addr[0]),
    .mem_byte_en(be[0]), .mem_wdata(wd[0]), .mem_ack(ack[0]),
    .mem_rdata(rd[0]), .mem_err(err[0]));

  qmem_ram #(.DEPTH(1024), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .mem_stb(stb[1]), .mem_addr(addr[1]),
    .mem_byte_en(be[1]), .mem_wdata(wd[1]), .mem_ack(ack[1]),
    .mem_rdata(rd[1]), .mem_err(err[1]));

  qmem_ram #(.DEPTH(1024), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .mem_stb(stb[2]), .mem_addr(addr[2]),
    .mem_byte_en(be[2]), .mem_wdata(wd[2]), .mem_ack(ack[2]),
    .mem_rdata(rd[2]), .mem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold stb until ack (bounded), then drop it after the ack edge.
  task automatic access(input int n, input logic [31:0] a, input logic [7:0] b, input logic [63:0] d);
    int  cyc;
    logic got;
    stb[n] = 1'b1; addr[n] = a; be[n] = b; wd[n] = d;
    got = 1'b0;
    cyc = 0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      if (ack[n]) got = 1'b1;
      tick();
      cyc++;
    end
    stb[n] = 1'b0; be[n] = 8'h00;
    check_val("acc_ack_seen", {63'd0, got}, 64'd1);
  endtask

  // W=0 write followed immediately by a read of the same word, with stb held throughout.
  task automatic w0_wr_rd(input logic [31:0] a, input logic [7:0] b, input logic [63:0] d,
                          input logic [63:0] prev, input logic [63:0] exp);
    stb[0] = 1'b1; addr[0] = a; be[0] = b; wd[0] = d;
    @(negedge clk);
    check_val("w0_wr_ack", {63'd0, ack[0]}, 64'd1);
    tick();
    be[0] = 8'h00;
    @(negedge clk);
    check_val("w0_rd_ack", {63'd0, ack[0]}, 64'd1);
    check_val("w0_wr_keeps_rdata", rd[0], prev);
    tick();
    stb[0] = 1'b0;
    check_val("w0_rdata", rd[0], exp);
    check_val("w0_err", {63'd0, err[0]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) begin
      stb[i] = 1'b0; addr[i] = 32'd0; be[i] = 8'h00; wd[i] = 64'd0;
    end
    rst_n  = 1'b0;
    stb[0] = 1'b1;

    // Reset state
    @(negedge clk);
    check_val("rst_ack_gated", {63'd0, ack[0]}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_rdata", rd[i], 64'd0);
      check_val("rst_err", {63'd0, err[i]}, 64'd0);
    end
    tick();
    stb[0] = 1'b0;
    rst_n  = 1'b1;
    tick();

    // 1/2: W=0 full write then read, then byte-lane merge
    w0_wr_rd(32'h10, 8'hFF, 64'h0011_2233_4455_6677, 64'd0, 64'h0011_2233_4455_6677);
    w0_wr_rd(32'h10, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 64'h0011_2233_4455_6677,
             64'h0011_2233_AAAA_BBBB);

    // 5: out-of-range handling and the last in-range word
    access(0, 32'h0, 8'hFF, C0);
    access(0, 32'h1FF8, 8'hFF, CT);
    check_val("top_wr_err", {63'd0, err[0]}, 64'd0);
    access(0, 32'h2000, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0);
    check_val("oor_wr_err", {63'd0, err[0]}, 64'd1);
    check_val("oor_wr_rdata_hold", rd[0], 64'h0011_2233_AAAA_BBBB);
    access(0, 32'h2000, 8'h00, 64'd0);
    check_val("oor_rd_rdata", rd[0], 64'd0);
    check_val("oor_rd_err", {63'd0, err[0]}, 64'd1);
    tick();
    check_val("oor_err_pulse", {63'd0, err[0]}, 64'd0);
    access(0, 32'h0, 8'h00, 64'd0);
    check_val("oor_no_alias", rd[0], C0);
    access(0, 32'h1FF8, 8'h00, 64'd0);
    check_val("top_rd", rd[0], CT);
    check_val("top_rd_err", {63'd0, err[0]}, 64'd0);

    // 3: W=3 ack timing, write first so that later reads have known data
    stb[2] = 1'b1; addr[2] = 32'h18; be[2] = 8'hFF; wd[2] = D3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("w3_ack_cycle", {63'd0, ack[2]}, {63'd0, (i == 3)});
      tick();
    end
    stb[2] = 1'b0; be[2] = 8'h00;
    check_val("w3_wr_rdata_hold", rd[2], 64'd0);
    // stb dropped at cycle 2: no ack
    stb[2] = 1'b1; addr[2] = 32'h18;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stb[2] = 1'b0;
      @(negedge clk);
      check_val("w3_drop_ack", {63'd0, ack[2]}, 64'd0);
      tick();
    end
    check_val("w3_drop_rdata", rd[2], 64'd0);
    stb[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("w3_restart_ack", {63'd0, ack[2]}, {63'd0, (i == 3)});
      tick();
    end
    stb[2] = 1'b0;
    check_val("w3_rd_data", rd[2], D3);

    // 4: W=2 requester switch while waiting
    access(1, 32'h20, 8'hFF, D4);
    access(1, 32'h28, 8'hFF, D5);
    stb[1] = 1'b1; addr[1] = 32'h20; be[1] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) addr[1] = 32'h28;
      @(negedge clk);
      check_val("w2_switch_ack", {63'd0, ack[1]}, {63'd0, (i == 2)});
      tick();
    end
    stb[1] = 1'b0;
    check_val("w2_switch_rdata", rd[1], D5);
    access(1, 32'h20, 8'h00, 64'd0);
    check_val("w2_rd_other", rd[1], D4);

    // 6: reset asserted during the wait of a pending write
    stb[2] = 1'b1; addr[2] = 32'h18; be[2] = 8'hFF; wd[2] = 64'h9999_9999_9999_9999;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid_ack", {63'd0, ack[2]}, 64'd0);
    check_val("rst_mid_rdata", rd[2], 64'd0);
    check_val("rst_mid_err", {63'd0, err[2]}, 64'd0);
    tick();
    be[2] = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post_rst_ack", {63'd0, ack[2]}, {63'd0, (i == 3)});
      tick();
    end
    stb[2] = 1'b0;
    check_val("post_rst_array", rd[2], D3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
